instr_mem_loadable: RTL and testbench

//  Parametrised instruction store for the IF stage. Filled at run time by a loader stream instead of a file read.

---
 rtl/instr_mem_loadable_pkg.sv | 16 +
 rtl/instr_mem_loadable_loader.sv | 64 ++++++
 rtl/instr_mem_loadable.sv | 95 +++++++++
 tb/tb_instr_mem_loadable.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// Shared types and helpers for the loadable instruction store.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package imem_pkg;

  typedef enum logic {IMEM_LOAD, IMEM_RUN} imem_state_t;

  // Single bit replicated to the full response width to form a NOP bundle.
  localparam logic NOP_WORD = 1'b0;

  // Byte address to word index (instructions are 4-byte aligned).
  function automatic logic [63:0] word_index(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/instr_mem_loadable_loader.sv
// LOAD/RUN control for the instruction store: write pointer and write enable.
// Latency: a word presented with load_valid is written on the same edge.
// Backpressure: load_ready is high for the whole LOAD state, low in RUN.
// Ports: clk/reset (async active-low), load_valid/load_last from the loader
//   stream, reload pulse from RUN; load_ready/loading/wr_en/wr_ptr to the top.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic             load_last,
  input  logic             reload,
  output logic             load_ready,
  output logic             loading,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr
);

  imem_state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IMEM_LOAD;
      wr_ptr  <= '0;
      loading <= 1'b1;
    end else begin
      case (state)
        IMEM_LOAD: begin
          // flush/reload are deliberately not observed here.
          if (load_valid) begin
            // Filling the last slot ends the load even without load_last.
            if (load_last || (wr_ptr == PTR_W'(DEPTH - 1))) begin
              state   <= IMEM_RUN;
              wr_ptr  <= '0;
              loading <= 1'b0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        IMEM_RUN: begin
          if (reload) begin
            state   <= IMEM_LOAD;
            wr_ptr  <= '0;
            loading <= 1'b1;
          end
        end
        default: begin
          state   <= IMEM_LOAD;
          wr_ptr  <= '0;
          loading <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = loading;
  assign wr_en      = load_valid && loading;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction store serving FETCH_WORDS words per fetch.
// Latency: 1 cycle from accepted fetch to resp_valid; back-to-back at full rate.
// Backpressure: a stalled response (resp_valid && !resp_ready) holds and blocks new fetches.
// Ports: loader stream (load_valid/load_data/load_last/load_ready), reload/loading,
//   fetch request (fetch_valid/fetch_addr/fetch_ready), flush, response
//   (resp_valid/resp_instr/resp_fault/resp_ready).
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WORDS = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_valid,
  input  logic [DATA_WIDTH-1:0]             load_data,
  input  logic                              load_last,
  output logic                              load_ready,
  input  logic                              reload,
  output logic                              loading,
  input  logic                              fetch_valid,
  input  logic [ADDR_WIDTH-1:0]             fetch_addr,
  output logic                              fetch_ready,
  input  logic                              flush,
  output logic                              resp_valid,
  output logic [FETCH_WORDS*DATA_WIDTH-1:0] resp_instr,
  output logic                              resp_fault,
  input  logic                              resp_ready
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RESP_W = FETCH_WORDS * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  fault_now;
  logic                  accept;
  logic [RESP_W-1:0]     rd_words;

  imem_loader #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_last  (load_last),
    .reload     (reload),
    .load_ready (load_ready),
    .loading    (loading),
    .wr_en      (wr_en),
    .wr_ptr     (wr_ptr)
  );

  // Storage is never cleared; contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= load_data;
  end

  assign idx       = ADDR_WIDTH'(word_index(64'(fetch_addr)));
  assign fault_now = (fetch_addr[1:0] != 2'b00) || (idx >= ADDR_WIDTH'(DEPTH));

  // Consecutive words wrap at the top of the array (DEPTH is a power of two).
  always_comb begin
    rd_words = '0;
    for (int i = 0; i < FETCH_WORDS; i++) begin
      rd_words[i*DATA_WIDTH +: DATA_WIDTH] = mem[idx[PTR_W-1:0] + PTR_W'(i)];
    end
  end

  // reload and flush both veto acceptance; outside RUN nothing is accepted.
  assign fetch_ready = !loading && !flush && !reload && (!resp_valid || resp_ready);
  assign accept      = fetch_valid && fetch_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_instr <= '0;
      resp_fault <= 1'b0;
    end else if (!loading && (reload || flush)) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_instr <= fault_now ? {RESP_W{NOP_WORD}} : rd_words;
      resp_fault <= fault_now;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int FW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_valid;
  logic [DW-1:0]   load_data;
  logic            load_last;
  logic            load_ready;
  logic            reload;
  logic            loading;
  logic            fetch_valid;
  logic [AW-1:0]   fetch_addr;
  logic            fetch_ready;
  logic            flush;
  logic            resp_valid;
  logic [FW*DW-1:0] resp_instr;
  logic            resp_fault;
  logic            resp_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0]    m_mem [DEPTH];
  int               m_wptr;
  bit               m_loading;
  bit               m_rv;
  logic [FW*DW-1:0] m_instr;
  bit               m_fault;

  always #5 clk = ~clk;

  instr_mem_loadable #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .FETCH_WORDS (FW)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .loading     (loading),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_instr  (resp_instr),
    .resp_fault  (resp_fault),
    .resp_ready  (resp_ready)
  );

  task automatic idle_inputs();
    load_valid = 0; load_data = '0; load_last = 0; reload = 0;
    fetch_valid = 0; fetch_addr = '0; flush = 0; resp_ready = 0;
  endtask

  task automatic model_reset();
    m_loading = 1; m_wptr = 0; m_rv = 0; m_instr = '0; m_fault = 0;
  endtask

  function automatic bit exp_fetch_ready();
    return !m_loading && !flush && !reload && (!m_rv || resp_ready);
  endfunction

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic step();
    longint unsigned widx;
    bit acc;
    bit flt;
    if (m_loading) begin
      if (load_valid) begin
        m_mem[m_wptr] = load_data;
        if (load_last || m_wptr == DEPTH - 1) begin
          m_loading = 0;
          m_wptr = 0;
        end else begin
          m_wptr++;
        end
      end
    end else begin
      acc = fetch_valid && exp_fetch_ready();
      if (reload) begin
        m_loading = 1; m_wptr = 0; m_rv = 0;
      end else if (flush) begin
        m_rv = 0;
      end else if (acc) begin
        widx = longint'(fetch_addr) / 4;
        flt = (fetch_addr % 4 != 0) || (widx >= DEPTH);
        m_rv = 1;
        m_fault = flt;
        for (int i = 0; i < FW; i++)
          m_instr[i*DW +: DW] = flt ? '0 : m_mem[(widx + longint'(i)) % DEPTH];
      end else if (resp_ready) begin
        m_rv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input bit last);
    load_valid = 1; load_data = d; load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    fetch_valid = 1; fetch_addr = a;
    step();
    fetch_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_instr !== '0) begin errors++; $display("FAIL reset_resp_instr: got %h expected 0", resp_instr); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL reset_resp_fault: got %b expected 0", resp_fault); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reset_loading: got %b expected 1", loading); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready: got %b expected 0", fetch_ready); end
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_basic();
    logic [FW*DW-1:0] exp;
    resp_ready = 1;
    load_word(32'h11, 0);
    load_word(32'h22, 0);
    load_word(32'h33, 0);
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL basic_loading_before_last: got %b expected 1", loading); end
    load_word(32'h44, 1);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL basic_loading_after_last: got %b expected 0", loading); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_load_ready_run: got %b expected 0", load_ready); end
    fetch(32'h8);
    exp = {32'h44, 32'h33};
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL basic_resp_valid: got %b expected 1", resp_valid); end
    checks++; if (resp_instr !== exp) begin errors++; $display("FAIL basic_resp_instr: got %h expected %h", resp_instr, exp); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL basic_resp_fault: got %b expected 0", resp_fault); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL basic_resp_drop: got %b expected 0", resp_valid); end
  endtask

  task automatic test_wrap_autofinish();
    logic [FW*DW-1:0] exp;
    resp_ready = 1;
    reload = 1; step(); reload = 0;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL wrap_reload_loading: got %b expected 1", loading); end
    for (int i = 0; i < DEPTH; i++) begin
      load_word((i == 0) ? 32'hBB : (i == DEPTH - 1) ? 32'hAA : $urandom, 0);
      if (i == DEPTH - 2) begin
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL wrap_loading_before_full: got %b expected 1", loading); end
      end
    end
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL wrap_auto_finish: got %b expected 0", loading); end
    fetch(32'h1C);
    exp = {32'hBB, 32'hAA};
    checks++; if (resp_instr !== exp) begin errors++; $display("FAIL wrap_resp_instr: got %h expected %h", resp_instr, exp); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL wrap_resp_fault: got %b expected 0", resp_fault); end
  endtask

  task automatic test_fault();
    logic [AW-1:0] addrs [6] = '{32'h6, 32'h20, 32'h400, 32'h1D, 32'h4, 32'h1E};
    bit            faults [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    resp_ready = 1;
    for (int k = 0; k < 6; k++) begin
      fetch(addrs[k]);
      checks++; if (resp_fault !== faults[k]) begin errors++; $display("FAIL fault_flag[%0h]: got %b expected %b", addrs[k], resp_fault, faults[k]); end
      checks++; if (resp_instr !== m_instr) begin errors++; $display("FAIL fault_instr[%0h]: got %h expected %h", addrs[k], resp_instr, m_instr); end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [FW*DW-1:0] hold;
    resp_ready = 1;
    fetch(AW'($urandom_range(0, DEPTH - 1)) << 2);
    hold = m_instr;
    resp_ready = 0;
    fetch_valid = 1;
    for (int c = 0; c < 3; c++) begin
      fetch_addr = AW'($urandom_range(0, DEPTH - 1)) << 2;
      #1;
      checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL bp_fetch_ready[%0d]: got %b expected 0", c, fetch_ready); end
      step();
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_resp_valid[%0d]: got %b expected 1", c, resp_valid); end
      checks++; if (resp_instr !== hold) begin errors++; $display("FAIL bp_resp_stable[%0d]: got %h expected %h", c, resp_instr, hold); end
    end
    resp_ready = 1;
    for (int c = 0; c < 12; c++) begin
      fetch_addr = AW'($urandom_range(0, DEPTH - 1)) << 2;
      #1;
      checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL b2b_fetch_ready[%0d]: got %b expected 1", c, fetch_ready); end
      step();
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp_valid[%0d]: got %b expected 1", c, resp_valid); end
      checks++; if (resp_instr !== m_instr) begin errors++; $display("FAIL b2b_resp_instr[%0d]: got %h expected %h", c, resp_instr, m_instr); end
    end
    fetch_valid = 0;
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", resp_valid); end
  endtask

  task automatic test_flush();
    resp_ready = 0;
    fetch(AW'($urandom_range(0, DEPTH - 1)) << 2);
    flush = 1; fetch_valid = 1;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL flush_fetch_ready: got %b expected 0", fetch_ready); end
    step();
    flush = 0; fetch_valid = 0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_valid: got %b expected 0", resp_valid); end
    step();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stray: got %b expected 0", resp_valid); end
  endtask

  task automatic test_reload();
    resp_ready = 0;
    fetch(AW'($urandom_range(0, DEPTH - 1)) << 2);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL reload_pending: got %b expected 1", resp_valid); end
    reload = 1; flush = 1; fetch_valid = 1;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reload_fetch_ready: got %b expected 0", fetch_ready); end
    step();
    reload = 0; flush = 0; fetch_valid = 0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reload_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reload_loading: got %b expected 1", loading); end
    // reload/flush while already loading must not disturb the load
    reload = 1; flush = 1;
    load_word($urandom, 0);
    reload = 0; flush = 0;
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL reload_ignored_in_load: got %b expected 1", loading); end
    for (int i = 1; i < DEPTH; i++) load_word($urandom, 0);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reload_auto_finish: got %b expected 0", loading); end
    resp_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fetch(AW'(i) << 2);
      checks++; if (resp_instr !== m_instr) begin errors++; $display("FAIL reload_readback[%0d]: got %h expected %h", i, resp_instr, m_instr); end
    end
    step();
  endtask

  task automatic test_reset_midload();
    logic [DW-1:0] w1, w2, y;
    logic [FW*DW-1:0] exp;
    w1 = $urandom; w2 = $urandom; y = $urandom;
    resp_ready = 1;
    reload = 1; step(); reload = 0;
    load_word(w1, 0);
    load_word(w2, 0);
    #2 reset = 0;
    #1;
    model_reset();
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL midreset_loading: got %b expected 1", loading); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midreset_load_ready: got %b expected 1", load_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_instr !== '0) begin errors++; $display("FAIL midreset_resp_instr: got %h expected 0", resp_instr); end
    checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL midreset_resp_fault: got %b expected 0", resp_fault); end
    checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL midreset_fetch_ready: got %b expected 0", fetch_ready); end
    @(posedge clk);
    #1;
    reset = 1;
    load_word(y, 1);
    fetch(32'h0);
    exp = {w2, y};
    checks++; if (resp_instr !== exp) begin errors++; $display("FAIL midreset_wrptr0: got %h expected %h", resp_instr, exp); end
    step();
  endtask

  task automatic test_random();
    bit efr;
    for (int c = 0; c < 300; c++) begin
      fetch_valid = ($urandom_range(0, 3) != 0);
      fetch_addr  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : (AW'($urandom_range(0, DEPTH - 1)) << 2);
      resp_ready  = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      #1;
      efr = exp_fetch_ready();
      checks++; if (fetch_ready !== efr) begin errors++; $display("FAIL rnd_fetch_ready[%0d]: got %b expected %b", c, fetch_ready, efr); end
      step();
      checks++; if (resp_valid !== m_rv) begin errors++; $display("FAIL rnd_resp_valid[%0d]: got %b expected %b", c, resp_valid, m_rv); end
      checks++; if (resp_fault !== m_fault) begin errors++; $display("FAIL rnd_resp_fault[%0d]: got %b expected %b", c, resp_fault, m_fault); end
      checks++; if (resp_instr !== m_instr) begin errors++; $display("FAIL rnd_resp_instr[%0d]: got %h expected %h", c, resp_instr, m_instr); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_wrap_autofinish();
    test_fault();
    test_backpressure();
    test_flush();
    test_reload();
    test_reset_midload();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
